// File: rtl/warp_pkg.sv
// Shared Wishbone widths, arbitration mode codes and the request payload
// used by the warp engine memory-port arbiter.
package warp_pkg;

    localparam int unsigned WB_AW     = 32;
    localparam int unsigned WB_DW     = 32;
    localparam int unsigned WB_SW     = 4;
    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic             we;
    } wb_req_t;

endpackage

// File: rtl/warp_rr_pick.sv
// Combinational N-way request picker: fixed priority (lowest index wins) or
// round-robin (first request found searching from i_ptr+1, wrapping).
module warp_rr_pick #(
    parameter int unsigned N    = 3,
    parameter int unsigned IDXW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    input  logic            i_mode,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    localparam int NI = int'(N);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int j;
        j       = 0;
        o_idx   = '0;
        o_valid = |i_req;
        if (!i_mode) begin
            for (int i = NI - 1; i >= 0; i--) begin
                if (i_req[i]) o_idx = IDXW'(i);
            end
        end else begin
            for (int k = NI; k >= 1; k--) begin
                j = int'(i_ptr) + k;
                if (j >= NI) j = j - NI;
                if (i_req[j]) o_idx = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/warp_arbiter_n.sv
// N-port Wishbone master arbiter: fixed or round-robin grant, bounded burst
// hold per grant, and a no-ack watchdog that aborts the granted port.
module warp_arbiter_n
    import warp_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned MODE      = 1,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [N*WB_AW-1:0]    s_adr_i,
    input  logic [N-1:0]          s_stb_i,
    input  logic [N-1:0]          s_we_i,
    input  logic [N*WB_DW-1:0]    s_dat_i,
    input  logic [N*WB_SW-1:0]    s_sel_i,
    output logic [N-1:0]          s_ack_o,
    output logic [N-1:0]          s_err_o,
    output logic [WB_DW-1:0]      s_dat_o,
    output logic [WB_AW-1:0]      mwb_adr_o,
    output logic                  mwb_cyc_o,
    output logic                  mwb_stb_o,
    output logic                  mwb_we_o,
    output logic [WB_DW-1:0]      mwb_dat_o,
    output logic [WB_SW-1:0]      mwb_sel_o,
    input  logic                  mwb_ack_i,
    input  logic [WB_DW-1:0]      mwb_dat_i,
    output logic [$clog2(N)-1:0]  grant_o,
    output logic                  busy_o
);

    localparam int unsigned IDXW    = $clog2(N);
    localparam int unsigned BCW     = $clog2(BURST_MAX + 1);
    localparam int unsigned WDW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned WD_LIM  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic        WDOG_EN = (TIMEOUT != 0);
    localparam logic        RR_MODE = (MODE == ARB_RR);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]      r_state, r_state_nxt;
    logic [IDXW-1:0] r_grant, r_grant_nxt;
    logic [IDXW-1:0] r_ptr,   r_ptr_nxt;
    logic [BCW-1:0]  r_burst, r_burst_nxt;
    logic [WDW-1:0]  r_wd,    r_wd_nxt;

    logic [IDXW-1:0] w_pick_idx;
    logic            w_pick_vld;
    logic            w_busy;
    logic            w_stb_g;
    logic            w_ack;
    logic            w_last;
    logic            w_timeout;
    logic [N-1:0]    w_gnt_oh;
    logic [BCW-1:0]  w_burst_inc;
    wb_req_t         w_req;

    warp_rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .i_req   (s_stb_i),
        .i_ptr   (r_ptr),
        .i_mode  (RR_MODE),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    // Select the granted requester's payload and strobe.
    always_comb begin
        w_req    = '0;
        w_stb_g  = 1'b0;
        w_gnt_oh = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_grant == IDXW'(i)) begin
                w_req.adr   = s_adr_i[i*WB_AW +: WB_AW];
                w_req.dat   = s_dat_i[i*WB_DW +: WB_DW];
                w_req.sel   = s_sel_i[i*WB_SW +: WB_SW];
                w_req.we    = s_we_i[i];
                w_stb_g     = s_stb_i[i];
                w_gnt_oh[i] = 1'b1;
            end
        end
    end

    assign w_busy      = (r_state == ST_BUSY);
    assign w_ack       = w_busy & w_stb_g & mwb_ack_i;
    assign w_burst_inc = r_burst + BCW'(1);
    assign w_last      = (w_burst_inc == BCW'(BURST_MAX));
    assign w_timeout   = WDOG_EN & w_busy & w_stb_g & ~mwb_ack_i & (r_wd == WDW'(WD_LIM));

    always_comb begin
        r_state_nxt = r_state;
        r_grant_nxt = r_grant;
        r_ptr_nxt   = r_ptr;
        r_burst_nxt = r_burst;
        r_wd_nxt    = r_wd;
        case (r_state)
            ST_IDLE: begin
                r_burst_nxt = '0;
                r_wd_nxt    = '0;
                if (w_pick_vld) begin
                    r_grant_nxt = w_pick_idx;
                    r_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_stb_g) begin
                    r_state_nxt = ST_IDLE;
                    r_ptr_nxt   = r_grant;
                end else if (w_ack) begin
                    r_burst_nxt = w_burst_inc;
                    r_wd_nxt    = '0;
                    if (w_last) begin
                        r_state_nxt = ST_IDLE;
                        r_ptr_nxt   = r_grant;
                    end
                end else if (w_timeout) begin
                    r_state_nxt = ST_IDLE;
                    r_ptr_nxt   = r_grant;
                end else if (WDOG_EN) begin
                    r_wd_nxt = r_wd + WDW'(1);
                end
            end
            default: r_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= IDXW'(N - 1);
            r_burst <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= r_state_nxt;
            r_grant <= r_grant_nxt;
            r_ptr   <= r_ptr_nxt;
            r_burst <= r_burst_nxt;
            r_wd    <= r_wd_nxt;
        end
    end

    // Master bus is driven only while a grant is active; IDLE drives zeros.
    always_comb begin
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_sel_o = '0;
        mwb_we_o  = 1'b0;
        mwb_stb_o = 1'b0;
        if (w_busy) begin
            mwb_adr_o = w_req.adr;
            mwb_dat_o = w_req.dat;
            mwb_sel_o = w_req.sel;
            mwb_we_o  = w_req.we;
            mwb_stb_o = w_stb_g;
        end
        s_ack_o = w_ack     ? w_gnt_oh : '0;
        s_err_o = w_timeout ? w_gnt_oh : '0;
    end

    assign mwb_cyc_o = w_busy;
    assign busy_o    = w_busy;
    assign grant_o   = r_grant;
    assign s_dat_o   = mwb_dat_i;

endmodule

// File: tb/tb_warp_arbiter_n.sv
// Directed bench for warp_arbiter_n: three configurations share one stimulus
// set; each scenario checks the instance whose parameters it targets.
module tb_warp_arbiter_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] s_adr;
    logic [2:0]  s_stb;
    logic [2:0]  s_we;
    logic [95:0] s_dat;
    logic [11:0] s_sel;
    logic        m_ack;
    logic [31:0] m_dat;

    logic [2:0]  a_ack, a_err, b_ack, b_err, c_ack, c_err;
    logic [31:0] a_sdat, b_sdat, c_sdat, a_adr, b_adr, c_adr, a_mdat, b_mdat, c_mdat;
    logic        a_cyc, b_cyc, c_cyc, a_stb, b_stb, c_stb, a_we, b_we, c_we;
    logic [3:0]  a_sel, b_sel, c_sel;
    logic [1:0]  a_grant, b_grant, c_grant;
    logic        a_busy, b_busy, c_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_g [5] = '{0, 1, 2, 0, 1};

    always #5 clk = ~clk;

    // A: fixed priority, burst 4, watchdog 8
    warp_arbiter_n #(.N(3), .MODE(0), .BURST_MAX(4), .TIMEOUT(8)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .s_adr_i(s_adr), .s_stb_i(s_stb), .s_we_i(s_we),
        .s_dat_i(s_dat), .s_sel_i(s_sel), .s_ack_o(a_ack), .s_err_o(a_err), .s_dat_o(a_sdat),
        .mwb_adr_o(a_adr), .mwb_cyc_o(a_cyc), .mwb_stb_o(a_stb), .mwb_we_o(a_we),
        .mwb_dat_o(a_mdat), .mwb_sel_o(a_sel), .mwb_ack_i(m_ack), .mwb_dat_i(m_dat),
        .grant_o(a_grant), .busy_o(a_busy));

    // B: round-robin, burst 1
    warp_arbiter_n #(.N(3), .MODE(1), .BURST_MAX(1), .TIMEOUT(64)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .s_adr_i(s_adr), .s_stb_i(s_stb), .s_we_i(s_we),
        .s_dat_i(s_dat), .s_sel_i(s_sel), .s_ack_o(b_ack), .s_err_o(b_err), .s_dat_o(b_sdat),
        .mwb_adr_o(b_adr), .mwb_cyc_o(b_cyc), .mwb_stb_o(b_stb), .mwb_we_o(b_we),
        .mwb_dat_o(b_mdat), .mwb_sel_o(b_sel), .mwb_ack_i(m_ack), .mwb_dat_i(m_dat),
        .grant_o(b_grant), .busy_o(b_busy));

    // C: round-robin, burst 4, watchdog disabled
    warp_arbiter_n #(.N(3), .MODE(1), .BURST_MAX(4), .TIMEOUT(0)) u_c (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .s_adr_i(s_adr), .s_stb_i(s_stb), .s_we_i(s_we),
        .s_dat_i(s_dat), .s_sel_i(s_sel), .s_ack_o(c_ack), .s_err_o(c_err), .s_dat_o(c_sdat),
        .mwb_adr_o(c_adr), .mwb_cyc_o(c_cyc), .mwb_stb_o(c_stb), .mwb_we_o(c_we),
        .mwb_dat_o(c_mdat), .mwb_sel_o(c_sel), .mwb_ack_i(m_ack), .mwb_dat_i(m_dat),
        .grant_o(c_grant), .busy_o(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        s_stb = 3'b000;
        s_we  = 3'b000;
        m_ack = 1'b0;
        m_dat = 32'hCAFE_0001;
        s_adr = {32'h2222_0000, 32'h1111_0000, 32'h0000_1000};
        s_dat = {32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
        s_sel = {4'hC, 4'h3, 4'hF};
        #2;
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_grant", 32'(a_grant), 32'd0);
        chk("rst_cyc",   32'(a_cyc),   32'd0);
        chk("rst_stb",   32'(a_stb),   32'd0);
        chk("rst_adr",   a_adr,        32'd0);
        chk("rst_ack",   32'(a_ack),   32'd0);
        chk("rst_sdat",  a_sdat,       32'hCAFE_0001);
        step();
        rst_n = 1'b1;

        // Ack with no requester in IDLE is ignored
        step();
        m_ack = 1'b1;
        settle();
        chk("idle_ack", 32'(a_ack), 32'd0);
        step();
        chk("idle_ack_busy", 32'(a_busy), 32'd0);
        chk("idle_ack_ack",  32'(a_ack),  32'd0);
        m_ack = 1'b0;

        // Fixed priority: ports 0 and 2 together
        pulse_reset();
        s_stb = 3'b101;
        s_we  = 3'b100;
        step();
        chk("fp_grant0", 32'(a_grant), 32'd0);
        chk("fp_busy0",  32'(a_busy),  32'd1);
        chk("fp_cyc0",   32'(a_cyc),   32'd1);
        chk("fp_adr0",   a_adr,        32'h0000_1000);
        chk("fp_sel0",   32'(a_sel),   32'hF);
        chk("fp_we0",    32'(a_we),    32'd0);
        m_ack = 1'b1;
        settle();
        chk("fp_ack0", 32'(a_ack), 32'b001);
        step();
        s_stb = 3'b100;
        m_ack = 1'b0;
        settle();
        chk("fp_stb_drop", 32'(a_stb), 32'd0);
        step();
        chk("fp_idle_gap", 32'(a_busy), 32'd0);
        step();
        chk("fp_grant2", 32'(a_grant), 32'd2);
        chk("fp_adr2",   a_adr,        32'h2222_0000);
        chk("fp_dat2",   a_mdat,       32'hD2D2_D2D2);
        chk("fp_we2",    32'(a_we),    32'd1);
        m_ack = 1'b1;
        settle();
        chk("fp_ack2", 32'(a_ack), 32'b100);
        s_stb = 3'b000;
        m_ack = 1'b0;
        s_we  = 3'b000;
        step();

        // Round-robin, one transfer per grant
        pulse_reset();
        s_stb = 3'b111;
        m_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_busy",  32'(b_busy),  32'd1);
            chk("rr_grant", 32'(b_grant), 32'(exp_g[k]));
            chk("rr_ack",   32'(b_ack),   32'(3'b001 << exp_g[k]));
            step();
            chk("rr_gap", 32'(b_busy), 32'd0);
        end
        s_stb = 3'b000;
        m_ack = 1'b0;
        step();

        // Burst limit: port 1 holds four transfers, then port 2 is served
        pulse_reset();
        s_stb = 3'b110;
        m_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bu_busy",  32'(c_busy),  32'd1);
            chk("bu_grant", 32'(c_grant), 32'd1);
            chk("bu_ack",   32'(c_ack),   32'b010);
        end
        step();
        chk("bu_idle", 32'(c_busy), 32'd0);
        step();
        chk("bu_grant2", 32'(c_grant), 32'd2);
        chk("bu_ack2",   32'(c_ack),   32'b100);
        s_stb = 3'b000;
        m_ack = 1'b0;
        step();

        // Watchdog abort on the eighth unacked BUSY cycle
        pulse_reset();
        s_stb = 3'b001;
        step();
        for (int k = 1; k < 8; k++) begin
            chk("wd_no_err", 32'(a_err),  32'd0);
            chk("wd_busy",   32'(a_busy), 32'd1);
            step();
        end
        chk("wd_err",      32'(a_err),  32'b001);
        chk("wd_err_ack",  32'(a_ack),  32'd0);
        chk("wd_err_busy", 32'(a_busy), 32'd1);
        step();
        chk("wd_abort_idle", 32'(a_busy), 32'd0);
        chk("wd_err_clear",  32'(a_err),  32'd0);
        s_stb = 3'b000;
        step();

        // Ack arriving on the timeout cycle wins
        pulse_reset();
        s_stb = 3'b001;
        step();
        for (int k = 1; k < 8; k++) step();
        m_ack = 1'b1;
        settle();
        chk("wd_tie_err", 32'(a_err), 32'd0);
        chk("wd_tie_ack", 32'(a_ack), 32'b001);
        step();
        m_ack = 1'b0;
        settle();
        chk("wd_tie_busy", 32'(a_busy), 32'd1);
        s_stb = 3'b000;
        step();
        step();

        // Asynchronous reset during a write
        pulse_reset();
        s_stb = 3'b100;
        s_we  = 3'b100;
        step();
        chk("ar_pre_stb",   32'(a_stb),   32'd1);
        chk("ar_pre_grant", 32'(a_grant), 32'd2);
        chk("ar_pre_we",    32'(a_we),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_stb",   32'(a_stb),   32'd0);
        chk("ar_cyc",   32'(a_cyc),   32'd0);
        chk("ar_grant", 32'(a_grant), 32'd0);
        chk("ar_busy",  32'(a_busy),  32'd0);
        s_stb = 3'b000;
        s_we  = 3'b000;
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
